// File: rtl/ov7670_capture_if.sv
// rtl/ov7670_capture_if.sv - frame buffer write bus between the capture block and the frame store
//
// Signals:
//   frame_addr  [16:0] linear row-major write address
//   frame_pixel [11:0] RGB444 write data {R,G,B}
//   frame_we           one-cycle write strobe per stored pixel
//   frame_done         one-cycle end-of-frame marker
// Modports:
//   master - driven by the capture block
//   slave  - consumed by the frame store
interface ov7670_capture_if;
    logic [16:0] frame_addr;
    logic [11:0] frame_pixel;
    logic        frame_we;
    logic        frame_done;

    modport master (
        output frame_addr,
        output frame_pixel,
        output frame_we,
        output frame_done
    );

    modport slave (
        input frame_addr,
        input frame_pixel,
        input frame_we,
        input frame_done
    );
endinterface

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB565 byte stream to RGB444 frame buffer writer
//
// Parameters:
//   H_PIXELS  pixels stored per line (default 320)
//   V_LINES   lines stored per frame (default 240)
// Ports:
//   clk25      camera pixel clock, everything happens on its rising edge
//   rst_n      asynchronous active-low reset
//   cam_vsync  high during frame blanking
//   cam_href   high while a line's bytes are on cam_data
//   cam_data   RGB565 bytes, high byte first
//   frame      ov7670_capture_if.master write bus (addr/pixel/we/done)
// Build option:
//   CAPTURE_FRAME_SKIP_EN  write only alternate frames (first, third, ...)
module ov7670_capture #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240
) (
    input  logic                    clk25,
    input  logic                    rst_n,
    input  logic                    cam_vsync,
    input  logic                    cam_href,
    input  logic [7:0]              cam_data,
    ov7670_capture_if.master        frame
);
    localparam int COL_W = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);
    localparam logic [17:0] LAST_ADDR = 18'(H_PIXELS * V_LINES - 1);
    localparam logic [17:0] LINE_STEP = 18'(H_PIXELS);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_PIXELS);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_LINES);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        IDLE,
        BYTE_HI,
        BYTE_LO
    } state_t;

    state_t              state, state_n;
    logic                vsync_q;
    logic [6:0]          hi_q, hi_n;        // only the high-byte bits used by RGB444
    logic [COL_W-1:0]    col, col_n;
    logic [LINE_W-1:0]   line, line_n;
    logic [16:0]         addr, addr_n;      // address of the next store
    logic [17:0]         line_base, base_n; // start address of the current line
    logic                wrote, wrote_n;
    logic [16:0]         out_addr, out_addr_n;
    logic [11:0]         out_pixel, out_pixel_n;
    logic                out_we, out_we_n;
    logic                out_done, out_done_n;

    logic                vsync_rise, vsync_fall;
    logic [17:0]         inc_addr, next_base;
    logic                skip_frame;

    assign vsync_rise = cam_vsync & ~vsync_q;
    assign vsync_fall = ~cam_vsync & vsync_q;
    assign inc_addr   = {1'b0, addr} + 18'd1;
    assign next_base  = line_base + LINE_STEP;

`ifdef CAPTURE_FRAME_SKIP_EN
    logic skip_frame_n;

    // Frame parity: the first frame after WAIT_FRAME is stored, then every other one.
    always_comb begin
        skip_frame_n = skip_frame;
        if (state == WAIT_FRAME) begin
            if (vsync_fall) begin
                skip_frame_n = 1'b0;
            end
        end else if (vsync_rise) begin
            skip_frame_n = ~skip_frame;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            skip_frame <= 1'b0;
        end else begin
            skip_frame <= skip_frame_n;
        end
    end
`else
    assign skip_frame = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        hi_n        = hi_q;
        col_n       = col;
        line_n      = line;
        addr_n      = addr;
        base_n      = line_base;
        wrote_n     = wrote;
        out_addr_n  = out_addr;
        out_pixel_n = out_pixel;
        out_we_n    = 1'b0;
        out_done_n  = 1'b0;

        if (state == WAIT_FRAME) begin
            if (vsync_fall) begin
                state_n    = IDLE;
                col_n      = '0;
                line_n     = '0;
                addr_n     = '0;
                base_n     = '0;
                wrote_n    = 1'b0;
                out_addr_n = '0;
            end
        end else if (vsync_rise) begin
            // New frame: close the old one and restart all counters.
            out_done_n = wrote;
            state_n    = IDLE;
            col_n      = '0;
            line_n     = '0;
            addr_n     = '0;
            base_n     = '0;
            wrote_n    = 1'b0;
            out_addr_n = '0;
        end else if (!cam_vsync) begin
            case (state)
                IDLE: begin
                    if (cam_href) begin
                        hi_n    = {cam_data[7:4], cam_data[2:0]};
                        state_n = BYTE_LO;
                    end
                end
                BYTE_LO: begin
                    if (cam_href) begin
                        state_n = BYTE_HI;
                        if (col < COL_MAX && line < LINE_MAX) begin
                            col_n  = col + 1'b1;
                            addr_n = (inc_addr > LAST_ADDR) ? LAST_ADDR[16:0] : inc_addr[16:0];
                            if (!skip_frame) begin
                                out_we_n    = 1'b1;
                                out_addr_n  = addr;
                                out_pixel_n = {hi_q[6:3], hi_q[2:0], cam_data[7], cam_data[4:1]};
                                wrote_n     = 1'b1;
                            end
                        end
                    end
                end
                BYTE_HI: begin
                    if (cam_href) begin
                        hi_n    = {cam_data[7:4], cam_data[2:0]};
                        state_n = BYTE_LO;
                    end
                end
                default: state_n = WAIT_FRAME;
            endcase

            // href fell inside a line: drop any half pixel and jump to the
            // next row start so short lines keep rows aligned.
            if (!cam_href && (state == BYTE_LO || state == BYTE_HI)) begin
                state_n = IDLE;
                col_n   = '0;
                if (line < LINE_MAX) begin
                    line_n = line + 1'b1;
                    base_n = next_base;
                    addr_n = (next_base > LAST_ADDR) ? LAST_ADDR[16:0] : next_base[16:0];
                end
            end
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_FRAME;
            vsync_q   <= 1'b0;
            hi_q      <= '0;
            col       <= '0;
            line      <= '0;
            addr      <= '0;
            line_base <= '0;
            wrote     <= 1'b0;
            out_addr  <= '0;
            out_pixel <= '0;
            out_we    <= 1'b0;
            out_done  <= 1'b0;
        end else begin
            state     <= state_n;
            vsync_q   <= cam_vsync;
            hi_q      <= hi_n;
            col       <= col_n;
            line      <= line_n;
            addr      <= addr_n;
            line_base <= base_n;
            wrote     <= wrote_n;
            out_addr  <= out_addr_n;
            out_pixel <= out_pixel_n;
            out_we    <= out_we_n;
            out_done  <= out_done_n;
        end
    end

    assign frame.frame_addr  = out_addr;
    assign frame.frame_pixel = out_pixel;
    assign frame.frame_we    = out_we;
    assign frame.frame_done  = out_done;
endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - directed scoreboard bench for ov7670_capture
module tb_ov7670_capture;
    localparam int H = 24;
    localparam int V = 6;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       cam_href = 1'b0;
    logic [7:0] cam_data = 8'h00;

    ov7670_capture_if frame ();

    ov7670_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .frame     (frame.master)
    );

    always #5 clk25 = ~clk25;

    int checks = 0;
    int errors = 0;

    logic [28:0] exp_q[$];
    logic [28:0] exp_w;
    int          write_cnt = 0;
    int          done_cnt = 0;
    logic [16:0] last_addr = '0;

    int          m_line = 0;
    bit          m_started = 0;
    bit          m_wrote = 0;
    bit          m_skip = 0;
    int          m_pushed = 0;
    int          exp_done = 0;
    logic [16:0] m_last = '0;

    always @(negedge clk25) begin
        if (frame.frame_done === 1'b1) done_cnt++;
        if (frame.frame_we === 1'b1) begin
            write_cnt++;
            last_addr = frame.frame_addr;
            checks++;
            if (exp_q.size() == 0) begin
                assert (frame.frame_we === 1'b0) else begin
                    errors++;
                    $error("FAIL unexpected_write addr=%0d pixel=%h, required no write", frame.frame_addr, frame.frame_pixel);
                end
            end else begin
                exp_w = exp_q.pop_front();
                assert ({frame.frame_addr, frame.frame_pixel} === exp_w) else begin
                    errors++;
                    $error("FAIL write addr=%0d pixel=%h, required addr=%0d pixel=%h",
                           frame.frame_addr, frame.frame_pixel, exp_w[28:12], exp_w[11:0]);
                end
            end
        end
    end

    function automatic logic [11:0] exp_pix(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0d required=%0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        cam_href = 1'b1;
        cam_data = b;
        tick();
    endtask

    task automatic expect_pixel(input int px, input logic [7:0] hi, input logic [7:0] lo);
        if (m_started && !m_skip && m_line < V && px < H) begin
            m_last = 17'(m_line * H + px);
            exp_q.push_back({m_last, exp_pix(hi, lo)});
            m_wrote = 1;
            m_pushed++;
        end
    endtask

    task automatic end_line();
        cam_href = 1'b0;
        cam_data = 8'h00;
        tick();
        tick();
        if (m_started) m_line++;
    endtask

    task automatic send_line(input int npix, input logic [7:0] hi, input logic [7:0] lo,
                             input bit vary, input bit orphan);
        logic [7:0] l;
        for (int p = 0; p < npix; p++) begin
            l = vary ? (lo ^ 8'(p * 37)) : lo;
            drive_byte(hi);
            expect_pixel(p, hi, l);
            drive_byte(l);
        end
        if (orphan) drive_byte(hi);
        end_line();
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        tick();
        if (m_started) begin
            if (m_wrote) exp_done++;
            m_wrote = 0;
            m_line = 0;
`ifdef CAPTURE_FRAME_SKIP_EN
            m_skip = ~m_skip;
`endif
        end
        // href during blanking must be ignored
        cam_href = 1'b1;
        cam_data = 8'hAA;
        tick();
        tick();
        cam_href = 1'b0;
        tick();
        cam_vsync = 1'b0;
        tick();
        if (!m_started) begin
            m_started = 1;
            m_skip = 0;
            m_line = 0;
            m_wrote = 0;
        end
        tick();
    endtask

    initial begin
        // reset state
        #2;
        check("reset_addr", 32'(frame.frame_addr), 0);
        check("reset_pixel", 32'(frame.frame_pixel), 0);
        check("reset_we", 32'(frame.frame_we), 0);
        check("reset_done", 32'(frame.frame_done), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // bytes before the first vsync fall are not stored
        send_line(4, 8'h55, 8'h66, 1'b0, 1'b0);
        check("wait_frame_writes", 32'(write_cnt), 0);

        vsync_pulse();
        check("first_vsync_done", 32'(done_cnt), 0);

        // single pixel, latency one cycle after the low byte
        drive_byte(8'h07);
        check("lat_we_before", 32'(frame.frame_we), 0);
        expect_pixel(0, 8'h07, 8'hFF);
        drive_byte(8'hFF);
        check("lat_we_after", 32'(frame.frame_we), 1);
        check("single_pixel", 32'(frame.frame_pixel), 32'h0FF);
        check("single_addr", 32'(frame.frame_addr), 0);
        end_line();

        // long line, short line, odd byte count, lines beyond V
        send_line(H + 10, 8'hA5, 8'h3C, 1'b1, 1'b0);
        send_line(5, 8'h12, 8'h34, 1'b1, 1'b0);
        send_line(3, 8'hFF, 8'hFF, 1'b0, 1'b0);
        send_line(4, 8'h80, 8'h01, 1'b1, 1'b1);
        send_line(2, 8'h0F, 8'hF0, 1'b0, 1'b0);
        send_line(3, 8'h44, 8'h44, 1'b0, 1'b0);
        check("shaped_frame_writes", 32'(write_cnt), 32'(m_pushed));
        vsync_pulse();
        check("shaped_frame_done", 32'(done_cnt), 32'(exp_done));

        // full frame plus two excess lines
        for (int ln = 0; ln < V + 2; ln++) send_line(H + 2, 8'hF8, 8'h00, 1'b0, 1'b0);
        check("full_frame_writes", 32'(write_cnt), 32'(m_pushed));
        check("full_frame_last_addr", 32'(last_addr), 32'(m_last));
        vsync_pulse();
        check("full_frame_done", 32'(done_cnt), 32'(exp_done));

        // vsync in the middle of a frame
        for (int ln = 0; ln < 3; ln++) send_line(H, 8'h9C, 8'h63, 1'b1, 1'b0);
        vsync_pulse();
        check("mid_frame_done", 32'(done_cnt), 32'(exp_done));
        send_line(2, 8'h21, 8'h43, 1'b0, 1'b0);
        check("restart_writes", 32'(write_cnt), 32'(m_pushed));

        // reset in the middle of a line while a write is visible
        drive_byte(8'h12);
        expect_pixel(0, 8'h12, 8'h34);
        drive_byte(8'h34);
        cam_data = 8'h56;
        @(negedge clk25);
        #1;
        check("pre_reset_we", 32'(frame.frame_we), 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_we", 32'(frame.frame_we), 0);
        check("mid_reset_addr", 32'(frame.frame_addr), 0);
        check("mid_reset_pixel", 32'(frame.frame_pixel), 0);
        m_started = 0;
        m_wrote = 0;
        m_line = 0;
        tick();
        rst_n = 1'b1;
        drive_byte(8'h78);
        drive_byte(8'h9A);
        end_line();
        send_line(3, 8'hC3, 8'h3C, 1'b0, 1'b0);
        check("post_reset_writes", 32'(write_cnt), 32'(m_pushed));
        vsync_pulse();
        check("post_reset_done", 32'(done_cnt), 32'(exp_done));
        send_line(2, 8'hE7, 8'h7E, 1'b1, 1'b0);

        // three short frames
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            send_line(3, 8'hB6, 8'h6B, 1'b1, 1'b0);
        end
        vsync_pulse();
        check("three_frame_writes", 32'(write_cnt), 32'(m_pushed));
        check("three_frame_done", 32'(done_cnt), 32'(exp_done));
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
